// File: rtl/ws2812_axil_pkg.sv
// Shared definitions for the WS2812 AXI4-Lite register slice.
// Register map indices, response code and byte-strobe merge helper.
package ws2812_axil_pkg;

    localparam int NUM_REGS  = 4;
    localparam int REG_CTRL  = 0;
    localparam int REG_COLOR = 1;
    localparam int REG_LEN   = 2;
    localparam int REG_AUX   = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  ridx_t;

    function automatic word_t strb_merge(
        input word_t      old_d,
        input word_t      new_d,
        input logic [3:0] strb
    );
        word_t res;
        res = old_d;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_d[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ws2812_axil_if.sv
// AXI4-Lite bus bundle between the lite master and the WS2812 regs.
// Master drives addresses, data and B/R ready; slave drives the rest.
interface ws2812_axil_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/ws2812_axil_regs.sv
// AXI4-Lite register file feeding the WS2812 strip timing engine.
// Four 32-bit regs, independent AW/W capture, write pulses per register.
module ws2812_axil_regs
    import ws2812_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    ws2812_axil_if.slave                  s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
    output logic [NUM_REGS-1:0]           reg_wr_o
);

    localparam int IDX_HI = C_S_AXI_ADDR_WIDTH - 1;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic          r_live;
    logic          r_aw_held;
    logic          r_w_held;
    ridx_t         r_aw_idx;
    word_t         r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_bvalid;
    logic [NUM_REGS-1:0] r_wr;
    logic          r_rvalid;
    word_t         r_rdata;

    logic  w_live;
    logic  w_aw_hs;
    logic  w_w_hs;
    logic  w_ar_hs;
    logic  w_commit;
    ridx_t w_aw_idx;
    ridx_t w_ar_idx;
    logic  w_unused;

    // READY stays low during reset and the cycle that samples its release
    assign w_live   = r_live & ~S_AXI_ARESET;
    assign w_aw_idx = s_axi.S_AXI_AWADDR[IDX_HI -: 2];
    assign w_ar_idx = s_axi.S_AXI_ARADDR[IDX_HI -: 2];

    assign s_axi.S_AXI_AWREADY = w_live & ~r_aw_held;
    assign s_axi.S_AXI_WREADY  = w_live & ~r_w_held;
    assign s_axi.S_AXI_ARREADY = w_live & ~r_rvalid;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign w_aw_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign w_w_hs   = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
    assign w_ar_hs  = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
    assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_wr      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_live <= 1'b1;
            r_wr   <= '0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= w_aw_idx;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.S_AXI_WDATA;
                r_wstrb  <= s_axi.S_AXI_WSTRB;
            end
            // Held beats wait here while a previous B is still pending
            if (w_commit) begin
                r_regs[r_aw_idx] <= strb_merge(r_regs[r_aw_idx], r_wdata, r_wstrb);
                r_wr[r_aw_idx]   <= 1'b1;
                r_bvalid         <= 1'b1;
                r_aw_held        <= 1'b0;
                r_w_held         <= 1'b0;
            end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Reads sample the register array before any same-edge commit lands
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_regs[w_ar_idx];
        end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign reg0_o   = r_regs[REG_CTRL];
    assign reg1_o   = r_regs[REG_COLOR];
    assign reg2_o   = r_regs[REG_LEN];
    assign reg3_o   = r_regs[REG_AUX];
    assign reg_wr_o = r_wr;

endmodule

// File: tb/tb_ws2812_axil_regs.sv
// Bench for ws2812_axil_regs: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the register file.
module tb_ws2812_axil_regs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ws2812_axil_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

    logic [31:0] r0, r1, r2, r3;
    logic [3:0]  wr;

    ws2812_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus.slave),
        .reg0_o       (r0),
        .reg1_o       (r1),
        .reg2_o       (r2),
        .reg3_o       (r3),
        .reg_wr_o     (wr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL timeout %s: got no handshake want handshake (t=%0t)", nm, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_reg [4];
    int          m_aw_q [$];
    logic [35:0] m_w_q [$];
    bit          m_b = 1'b0;
    bit          m_r = 1'b0;
    bit          m_live = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [3:0]  m_pulse = '0;
    int          pc [4];
    int          bcnt = 0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_reg[i] = '0;
            pc[i]    = 0;
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    always @(negedge clk) begin
        bit          e_aw, e_w, e_ar, cm;
        int          idx;
        logic [35:0] wv;
        logic [3:0]  np;
        e_aw = !rst && m_live && (m_aw_q.size() == 0);
        e_w  = !rst && m_live && (m_w_q.size() == 0);
        e_ar = !rst && m_live && !m_r;
        chk("awready", 32'(bus.S_AXI_AWREADY), 32'(e_aw));
        chk("wready",  32'(bus.S_AXI_WREADY),  32'(e_w));
        chk("arready", 32'(bus.S_AXI_ARREADY), 32'(e_ar));
        chk("bvalid",  32'(bus.S_AXI_BVALID),  32'(m_b));
        chk("rvalid",  32'(bus.S_AXI_RVALID),  32'(m_r));
        chk("rdata",   bus.S_AXI_RDATA, m_rdata);
        chk("bresp",   32'(bus.S_AXI_BRESP), 32'd0);
        chk("rresp",   32'(bus.S_AXI_RRESP), 32'd0);
        chk("reg0", r0, m_reg[0]);
        chk("reg1", r1, m_reg[1]);
        chk("reg2", r2, m_reg[2]);
        chk("reg3", r3, m_reg[3]);
        chk("reg_wr", 32'(wr), 32'(m_pulse));
        for (int i = 0; i < 4; i++) if (wr[i] === 1'b1) pc[i]++;
        if (bus.S_AXI_BVALID === 1'b1) bcnt++;

        if (rst) begin
            m_aw_q.delete();
            m_w_q.delete();
            m_b = 0; m_r = 0; m_rdata = '0; m_pulse = '0; m_live = 0;
            for (int i = 0; i < 4; i++) m_reg[i] = '0;
        end else begin
            m_live = 1;
            np = '0;
            if (m_r && bus.S_AXI_RREADY) m_r = 0;
            if (bus.S_AXI_ARVALID && e_ar) begin
                m_r = 1;
                m_rdata = m_reg[bus.S_AXI_ARADDR[3:2]];
            end
            cm = (m_aw_q.size() > 0) && (m_w_q.size() > 0) && !m_b;
            if (m_b && bus.S_AXI_BREADY) m_b = 0;
            if (cm) begin
                idx = m_aw_q.pop_front();
                wv  = m_w_q.pop_front();
                m_reg[idx] = merge(m_reg[idx], wv[31:0], wv[35:32]);
                np[idx] = 1'b1;
                m_b = 1;
            end
            if (bus.S_AXI_AWVALID && e_aw) m_aw_q.push_back(int'(bus.S_AXI_AWADDR[3:2]));
            if (bus.S_AXI_WVALID && e_w) m_w_q.push_back({bus.S_AXI_WSTRB, bus.S_AXI_WDATA});
            m_pulse = np;
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_beat(input logic [3:0] a, input int dly);
        bit hs;
        int n;
        repeat (dly) step();
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWPROT  = 3'($urandom);
        bus.S_AXI_AWVALID = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.S_AXI_AWREADY;
            step();
            n++;
        end
        bus.S_AXI_AWVALID = 1'b0;
        if (!hs) tmo("aw");
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                          input int dly);
        bit hs;
        int n;
        repeat (dly) step();
        bus.S_AXI_WDATA  = d;
        bus.S_AXI_WSTRB  = s;
        bus.S_AXI_WVALID = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.S_AXI_WREADY;
            step();
            n++;
        end
        bus.S_AXI_WVALID = 1'b0;
        if (!hs) tmo("w");
    endtask

    task automatic ar_beat(input logic [3:0] a);
        bit hs;
        int n;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARPROT  = 3'($urandom);
        bus.S_AXI_ARVALID = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.S_AXI_ARREADY;
            step();
            n++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        if (!hs) tmo("ar");
    endtask

    task automatic wait_b(input int hold);
        bit hs;
        int n, seen;
        bus.S_AXI_BREADY = (hold == 0);
        hs = 0; n = 0; seen = 0;
        while (!hs && n < 300) begin
            @(negedge clk);
            if (bus.S_AXI_BVALID) begin
                if (bus.S_AXI_BREADY) hs = 1;
                else seen++;
            end
            step();
            n++;
            if (seen >= hold) bus.S_AXI_BREADY = 1'b1;
        end
        bus.S_AXI_BREADY = 1'b1;
        if (!hs) tmo("b");
    endtask

    task automatic wait_r(input int hold, output logic [31:0] d);
        bit hs;
        int n, seen;
        bus.S_AXI_RREADY = (hold == 0);
        hs = 0; n = 0; seen = 0; d = 'x;
        while (!hs && n < 300) begin
            @(negedge clk);
            if (bus.S_AXI_RVALID) begin
                if (bus.S_AXI_RREADY) begin
                    hs = 1;
                    d  = bus.S_AXI_RDATA;
                end else begin
                    seen++;
                end
            end
            step();
            n++;
            if (seen >= hold) bus.S_AXI_RREADY = 1'b1;
        end
        bus.S_AXI_RREADY = 1'b1;
        if (!hs) tmo("r");
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lead,
                             input int hold);
        fork
            aw_beat(a, (lead > 0) ? lead : 0);
            w_beat(d, s, (lead < 0) ? -lead : 0);
        join
        wait_b(hold);
    endtask

    task automatic axi_read(input logic [3:0] a, input int hold,
                            output logic [31:0] d);
        ar_beat(a);
        wait_r(hold, d);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] seq_d [4];
    logic [31:0] rd, rd2;
    int          p0, psum, bc0;

    initial begin
        seq_d[0] = 32'h0101FFFF;
        seq_d[1] = 32'hABCD0001;
        seq_d[2] = 32'hDEAD0011;
        seq_d[3] = 32'hBEEF0011;
        bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 0;
        bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 0;
        bus.S_AXI_BREADY = 1;
        bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 0;
        bus.S_AXI_RREADY = 1;
        rst = 1'b1;
        repeat (4) step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("awready after reset", 32'(bus.S_AXI_AWREADY), 32'd1);
        step();

        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), seq_d[i], 4'hF, 0, 0);
            axi_read(4'(i * 4), 0, rd);
            chk("seq readback", rd, seq_d[i]);
        end

        p0 = pc[1];
        axi_write(4'h4, 32'h11223344, 4'b0101, 0, 0);
        axi_read(4'h5, 0, rd);
        chk("strobe readback", rd, 32'hAB220044);
        chk("strobe model pin", m_reg[1], 32'hAB220044);
        chk("strobe pulse count", 32'(pc[1] - p0), 32'd1);

        axi_write(4'h8, 32'h5A5A5A5A, 4'hF, 3, 0);
        axi_read(4'hA, 0, rd);
        chk("w-before-aw readback", rd, 32'h5A5A5A5A);

        fork
            axi_write(4'hC, 32'h600DF00D, 4'hF, 0, 5);
            begin
                repeat (3) step();
                fork
                    aw_beat(4'h0, 0);
                    w_beat(32'h12345678, 4'hF, 0);
                join
            end
        join
        repeat (4) step();
        axi_read(4'hC, 4, rd);
        chk("backpressure rd reg3", rd, 32'h600DF00D);
        axi_read(4'h0, 0, rd);
        chk("queued write reg0", rd, 32'h12345678);

        axi_write(4'h4, 32'hABCD0001, 4'hF, 0, 0);
        fork
            axi_write(4'h4, 32'h00000077, 4'hF, 0, 0);
            begin
                step();
                axi_read(4'h4, 0, rd);
            end
        join
        chk("collision old value", rd, 32'hABCD0001);
        axi_read(4'h4, 0, rd2);
        chk("collision new value", rd2, 32'h00000077);

        psum = pc[0] + pc[1] + pc[2] + pc[3];
        bc0  = bcnt;
        aw_beat(4'h0, 0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("awready post reset", 32'(bus.S_AXI_AWREADY), 32'd1);
        chk("wready post reset",  32'(bus.S_AXI_WREADY),  32'd1);
        chk("arready post reset", 32'(bus.S_AXI_ARREADY), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 0, rd);
            chk("reg zero after reset", rd, 32'd0);
        end
        chk("no bvalid after reset", 32'(bcnt - bc0), 32'd0);
        chk("no pulse after reset",
            32'(pc[0] + pc[1] + pc[2] + pc[3] - psum), 32'd0);

        fork
            for (int k = 0; k < 120; k++) begin
                axi_write(4'($urandom), $urandom, 4'($urandom),
                          int'($urandom_range(6)) - 3,
                          int'($urandom_range(3)));
                repeat ($urandom_range(2)) step();
            end
            for (int k = 0; k < 120; k++) begin
                axi_read(4'($urandom), int'($urandom_range(3)), rd2);
                repeat ($urandom_range(2)) step();
            end
        join
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws2812_axil_regs.md
# ws2812_axil_regs

AXI4-Lite slave register file for the WS2812 strip IP: the responder end of the S00_AXI port driven by the lite master BFM in the block-design bench. It accepts single-beat writes and reads on four 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC, and presents the register contents plus per-register write pulses to the strip timing engine. AW and W are accepted independently in either order, and B/R backpressure is honoured.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: address width; only bits [3:2] are decoded.

Ports:
- S_AXI_ACLK  in  1  the single clock.
- S_AXI_ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- reg0_o..reg3_o  out  32 each  current register contents.
- reg_wr_o  out  4  one-cycle pulse, bit i set on the cycle reg i is updated.

## Operation
Write path:
- Holding flags aw_held and w_held latch the address and the data/strobe respectively.
- AWREADY = ~aw_held; WREADY = ~w_held.
- Commit occurs when aw_held & w_held & ~BVALID:
  - Register AWADDR[3:2] is updated byte-wise under WSTRB (a byte whose strobe is 0 keeps its old value).
  - reg_wr_o[idx] pulses.
  - BVALID is set.
  - Both holding flags clear.
- BVALID stays high until BREADY is sampled high.
- A second AW or W beat may be accepted while BVALID is pending. It is held, and commits once BVALID clears.

Read path:
- ARREADY = ~RVALID.
- On the AR handshake, RDATA is loaded from the register at ARADDR[3:2] and RVALID is set.
- RDATA and RVALID are held stable until RREADY is sampled high.

Common rules:
- Address bits [1:0] are ignored.
- Response is always OKAY. There is no decode error.
- Read and write paths are fully independent.
- Simultaneous commit and read of the same register: the read returns the pre-write value.

## Timing
- Reset values:
  - All READY outputs are 0 while S_AXI_ARESET is high.
  - BVALID = 0, RVALID = 0, RDATA = 0, BRESP = 0, RRESP = 0.
  - reg0..3 = 0; reg_wr_o = 0; holding flags clear.
  - AWREADY, WREADY and ARREADY are 1 from the first cycle after reset is sampled low.
- Write latency, AW and W in the same cycle N:
  - Held at edge N+1.
  - Commit at the end of cycle N+1.
  - Register, reg_wr_o and BVALID visible in cycle N+2.
- Write latency, AW and W split: commit occurs one cycle after the later beat is accepted.
- Read latency: AR handshake in cycle N gives RVALID and RDATA in cycle N+1.
- Throughput: with BREADY/RREADY tied high, at most one write per 2 cycles and one read per 2 cycles.
- Reset asserted mid-transaction:
  - Held beats are discarded.
  - Pending BVALID/RVALID drop to 0 at the next edge.
  - Registers return to 0.
  - No reg_wr_o pulse is produced.

## Structure
- Shared package ws2812_axil_pkg holds:
  - register index constants (REG_CTRL=0, REG_COLOR=1, REG_LEN=2, REG_AUX=3);
  - RESP_OKAY = 2'b00;
  - NUM_REGS = 4;
  - the strobe-merge function (old, new, strb) returning merged data.
- No sub-module. Read and write channel logic sit in one file, as two separate always blocks.

## Test plan
- Sequential write/read-back: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read of the same address → each read returns its written value. All responses OKAY.
- Byte strobes: reg1 = 0xABCD0001, then write 0x11223344 with WSTRB=4'b0101 → reg1 reads 0xAB220044. reg_wr_o[1] pulses once.
- Channel ordering: W presented 3 cycles before AW at 0x8 with data 0x5A5A5A5A → WREADY drops after acceptance, commit occurs one cycle after the AW handshake, reg2 = 0x5A5A5A5A.
- Backpressure: BREADY=0 for 5 cycles after the write, then RREADY=0 for 4 cycles on a read of 0xC → BVALID and RVALID are held with stable RDATA. ARREADY stays 0 while RVALID is high. The second write waits in the holding regs until B completes.
- Same-cycle collision: read of 0x4 issued in the commit cycle of a write 0x00000077 to 0x4 (old value 0xABCD0001) → the read returns 0xABCD0001. The next read returns 0x00000077.
- Reset mid-write: assert S_AXI_ARESET after the AW handshake but before W → BVALID never rises, reg0..3 read 0, no reg_wr_o pulse, READY outputs are 1 one cycle after release.
